// File: rtl/vector_map_seq_if.sv
// Valid/ready bundle for vector_map_seq: upstream vector in, mapped result out.
// The master drives the vector and o_ready; the slave (the map block) drives the rest.
interface vector_map_seq_if #(
    parameter int ELEMS = 5,
    parameter int WIDTH = 4
);
    localparam int SW = $clog2(ELEMS + 1);

    logic [ELEMS*WIDTH-1:0] i_data;
    logic [1:0]             i_op;
    logic [WIDTH-1:0]       i_operand;
    logic                   i_valid;
    logic                   i_ready;
    logic [ELEMS*WIDTH-1:0] o_data;
    logic [SW-1:0]          o_sat_count;
    logic                   o_valid;
    logic                   o_ready;

    modport master (
        output i_data, i_op, i_operand, i_valid, o_ready,
        input  i_ready, o_data, o_sat_count, o_valid
    );

    modport slave (
        input  i_data, i_op, i_operand, i_valid, o_ready,
        output i_ready, o_data, o_sat_count, o_valid
    );
endinterface

// File: rtl/vector_map_seq.sv
// Time-multiplexed vector map: applies PASS/ADD_WRAP/ADD_SAT/SUB_SAT with a scalar
// operand to a captured vector, LANES elements per cycle, and holds the result until accepted.
module vector_map_seq #(
    parameter int ELEMS = 5,
    parameter int WIDTH = 4,
    parameter int LANES = 2
) (
    input  logic            clock,
    input  logic            reset,
    vector_map_seq_if.slave bus
);
    localparam int CHUNKS = (ELEMS + LANES - 1) / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SW     = $clog2(ELEMS + 1);
    localparam int DW     = ELEMS * WIDTH;
    localparam int IW     = $clog2(CHUNKS * LANES) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CW-1:0]               r_chunk;
    logic [DW-1:0]               r_vec;
    logic [DW-1:0]               r_result;
    logic [1:0]                  r_op;
    logic [WIDTH-1:0]            r_operand;
    logic [SW-1:0]               r_sat_count;
    logic [LANES-1:0][WIDTH-1:0] w_lane_y;
    logic [LANES-1:0]            w_lane_sat;
    logic [SW-1:0]               w_chunk_sat;
    logic                        w_accept;
    logic                        w_last;
    logic                        w_i_ready;
    logic                        w_o_valid;

    assign w_last   = (r_chunk == CW'(CHUNKS - 1));
    assign w_accept = (r_state == IDLE) && bus.i_valid;

    // One ALU per lane; the padding lanes of a short final chunk never raise a clamp.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IW-1:0]    w_idx;
        logic             w_en;
        logic [WIDTH-1:0] w_x;
        logic [WIDTH:0]   w_sum;
        logic [WIDTH:0]   w_diff;
        logic [WIDTH-1:0] w_y;
        logic             w_sat;

        assign w_idx  = IW'(r_chunk) * IW'(LANES) + IW'(gi);
        assign w_en   = (w_idx < IW'(ELEMS));
        assign w_x    = w_en ? r_vec[w_idx*WIDTH +: WIDTH] : '0;
        assign w_sum  = {1'b0, w_x} + {1'b0, r_operand};
        assign w_diff = {1'b0, w_x} - {1'b0, r_operand};

        always_comb begin
            w_y   = w_x;
            w_sat = 1'b0;
            case (r_op)
                2'd1: w_y = w_sum[WIDTH-1:0];
                2'd2: begin
                    if (w_sum[WIDTH]) begin
                        w_y   = '1;
                        w_sat = w_en;
                    end else begin
                        w_y = w_sum[WIDTH-1:0];
                    end
                end
                2'd3: begin
                    if (w_diff[WIDTH]) begin
                        w_y   = '0;
                        w_sat = w_en;
                    end else begin
                        w_y = w_diff[WIDTH-1:0];
                    end
                end
                default: w_y = w_x;
            endcase
        end

        assign w_lane_y[gi]   = w_y;
        assign w_lane_sat[gi] = w_sat;
    end

    always_comb begin
        w_chunk_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            w_chunk_sat = w_chunk_sat + SW'(w_lane_sat[i]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_i_ready    = 1'b0;
        w_o_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                w_i_ready = 1'b1;
                if (bus.i_valid) w_state_next = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_o_valid = 1'b1;
                if (bus.o_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_chunk     <= '0;
            r_vec       <= '0;
            r_result    <= '0;
            r_op        <= '0;
            r_operand   <= '0;
            r_sat_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_vec       <= bus.i_data;
                r_op        <= bus.i_op;
                r_operand   <= bus.i_operand;
                r_result    <= '0;
                r_sat_count <= '0;
                r_chunk     <= '0;
            end else if (r_state == BUSY) begin
                // Element k always comes from lane k%LANES during chunk k/LANES.
                for (int k = 0; k < ELEMS; k++) begin
                    if (r_chunk == CW'(k / LANES)) begin
                        r_result[k*WIDTH +: WIDTH] <= w_lane_y[k % LANES];
                    end
                end
                r_sat_count <= r_sat_count + w_chunk_sat;
                r_chunk     <= w_last ? '0 : r_chunk + CW'(1);
            end
        end
    end

    assign bus.i_ready     = w_i_ready;
    assign bus.o_valid     = w_o_valid;
    assign bus.o_data      = r_result;
    assign bus.o_sat_count = r_sat_count;
endmodule

// File: tb/tb_vector_map_seq.sv
// Runs LANES=2, 5 and 1 instances in lockstep on the same vectors, checking each
// against an element-wise arithmetic model of the map, plus literal expectations.
module tb_vector_map_seq;
    localparam int ELEMS = 5;
    localparam int WIDTH = 4;
    localparam int DW    = ELEMS * WIDTH;
    localparam int SW    = $clog2(ELEMS + 1);
    localparam int NI    = 3;

    function automatic int lanes_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 5 : 1);
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            sat;
        int            t_acc;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [DW-1:0]    tb_data;
    logic [1:0]       tb_op;
    logic [WIDTH-1:0] tb_operand;
    logic             tb_valid;
    logic             tb_oready;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    exp_t          exp_q    [NI][$];
    logic [NI-1:0] rdy_all;
    logic [NI-1:0] vld_all;
    logic [DW-1:0] data_all [NI];
    logic [SW-1:0] sat_all  [NI];
    logic [DW-1:0] last_data[NI];
    int            last_sat [NI];
    int            hs_count [NI] = '{0, 0, 0};

    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {4'(a), 4'(b), 4'(c), 4'(d), 4'(e)};
    endfunction

    // Element-wise reference: each element mapped independently with integer arithmetic.
    function automatic void model(input logic [DW-1:0] d, input logic [1:0] op,
                                  input logic [WIDTH-1:0] k_opnd,
                                  output logic [DW-1:0] y, output int sat);
        int x, r, m, opnd;
        m    = (1 << WIDTH) - 1;
        opnd = int'(k_opnd);
        sat  = 0;
        y    = '0;
        for (int e = 0; e < ELEMS; e++) begin
            x = int'(d[e*WIDTH +: WIDTH]);
            case (op)
                2'd0: r = x;
                2'd1: r = (x + opnd) % (m + 1);
                2'd2: if (x + opnd > m) begin r = m; sat++; end else r = x + opnd;
                default: if (opnd > x) begin r = 0; sat++; end else r = x - opnd;
            endcase
            y[e*WIDTH +: WIDTH] = WIDTH'(r);
        end
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int L = lanes_of(gi);
        localparam int C = (ELEMS + L - 1) / L;

        vector_map_seq_if #(.ELEMS(ELEMS), .WIDTH(WIDTH)) bus ();

        assign bus.i_data    = tb_data;
        assign bus.i_op      = tb_op;
        assign bus.i_operand = tb_operand;
        assign bus.i_valid   = tb_valid;
        assign bus.o_ready   = tb_oready;
        assign rdy_all[gi]   = bus.i_ready;
        assign vld_all[gi]   = bus.o_valid;
        assign data_all[gi]  = bus.o_data;
        assign sat_all[gi]   = bus.o_sat_count;

        vector_map_seq #(.ELEMS(ELEMS), .WIDTH(WIDTH), .LANES(L)) dut (
            .clock(clock),
            .reset(reset),
            .bus  (bus.slave)
        );

        bit seen = 1'b0;

        always @(negedge clock) begin
            if (reset) begin
                seen = 1'b0;
            end else if (exp_q[gi].size() == 0) begin
                chk($sformatf("L%0d_idle_valid", L), 32'(bus.o_valid), 0);
                chk($sformatf("L%0d_idle_ready", L), 32'(bus.i_ready), 1);
            end else if (bus.o_valid) begin
                if (!seen) begin
                    chk($sformatf("L%0d_latency", L), 32'(cycle - exp_q[gi][0].t_acc), 32'(C));
                    seen = 1'b1;
                end
                chk($sformatf("L%0d_data", L), 32'(bus.o_data), 32'(exp_q[gi][0].data));
                chk($sformatf("L%0d_sat", L), 32'(bus.o_sat_count), 32'(exp_q[gi][0].sat));
                chk($sformatf("L%0d_done_ready", L), 32'(bus.i_ready), 0);
                if (tb_oready) begin
                    last_data[gi] = bus.o_data;
                    last_sat[gi]  = int'(bus.o_sat_count);
                    hs_count[gi]++;
                    void'(exp_q[gi].pop_front());
                    seen = 1'b0;
                end
            end else begin
                chk($sformatf("L%0d_busy_ready", L), 32'(bus.i_ready), 0);
                chk($sformatf("L%0d_not_late", L), 32'(cycle - exp_q[gi][0].t_acc < C), 1);
            end
        end
    end

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NI; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [1:0] op, input logic [WIDTH-1:0] opnd);
        int   n = 0;
        exp_t e;
        while (rdy_all != {NI{1'b1}} && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("send_ready", 32'(rdy_all), 32'({NI{1'b1}}));
        tb_data    = d;
        tb_op      = op;
        tb_operand = opnd;
        tb_valid   = 1'b1;
        model(d, op, opnd, e.data, e.sat);
        @(posedge clock); #1;
        tb_valid = 1'b0;
        e.t_acc  = cycle;
        for (int i = 0; i < NI; i++) exp_q[i].push_back(e);
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (pending() != 0 && n < 200) begin
            if (rnd) begin
                tb_oready  = ($urandom_range(0, 3) != 0);
                tb_data    = DW'($urandom);
                tb_op      = 2'($urandom);
                tb_operand = WIDTH'($urandom);
            end
            @(posedge clock); #1;
            n++;
        end
        chk("drain_timeout", 32'(pending()), 0);
        tb_oready = 1'b1;
    endtask

    task automatic run_dir(input string name, input logic [DW-1:0] d, input logic [1:0] op,
                           input logic [WIDTH-1:0] opnd, input logic [DW-1:0] exp_d, input int exp_s);
        logic [DW-1:0] my;
        int            ms;
        model(d, op, opnd, my, ms);
        chk({name, "_model_data"}, 32'(my), 32'(exp_d));
        chk({name, "_model_sat"}, 32'(ms), 32'(exp_s));
        send(d, op, opnd);
        drain(1'b0);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_L%0d_data", name, lanes_of(i)), 32'(last_data[i]), 32'(exp_d));
            chk($sformatf("%s_L%0d_sat", name, lanes_of(i)), 32'(last_sat[i]), 32'(exp_s));
        end
    endtask

    initial begin
        int            n;
        int            hs0 [NI];
        logic [DW-1:0] rd;
        logic [1:0]    rop;
        logic [WIDTH-1:0] ropnd;

        reset      = 1'b1;
        tb_valid   = 1'b0;
        tb_oready  = 1'b1;
        tb_data    = '0;
        tb_op      = '0;
        tb_operand = '0;
        #2;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", 32'(vld_all[i]), 0);
            chk("rst_ready", 32'(rdy_all[i]), 1);
            chk("rst_data", 32'(data_all[i]), 0);
            chk("rst_sat", 32'(sat_all[i]), 0);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        run_dir("add_wrap1", pk(1, 2, 3, 4, 5), 2'd1, 4'd1, pk(2, 3, 4, 5, 6), 0);
        run_dir("add_sat12", pk(1, 2, 3, 4, 5), 2'd2, 4'd12, pk(13, 14, 15, 15, 15), 2);
        run_dir("add_wrap12", pk(1, 2, 3, 4, 5), 2'd1, 4'd12, pk(13, 14, 15, 0, 1), 0);
        run_dir("sub_sat3", pk(1, 2, 3, 4, 5), 2'd3, 4'd3, pk(0, 0, 0, 1, 2), 2);

        // Backpressure: result held while o_ready is low and inputs wander.
        tb_oready = 1'b0;
        send(pk(1, 2, 3, 4, 5), 2'd0, 4'd0);
        n = 0;
        while (vld_all != {NI{1'b1}} && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("bp_all_done", 32'(vld_all), 32'({NI{1'b1}}));
        for (int i = 0; i < NI; i++) hs0[i] = hs_count[i];
        repeat (5) begin
            tb_data = DW'($urandom);
            @(posedge clock); #1;
            for (int i = 0; i < NI; i++) begin
                chk("bp_valid", 32'(vld_all[i]), 1);
                chk("bp_iready", 32'(rdy_all[i]), 0);
                chk("bp_data", 32'(data_all[i]), 32'(pk(1, 2, 3, 4, 5)));
            end
        end
        tb_oready = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < NI; i++) begin
            chk("bp_one_handshake", 32'(hs_count[i] - hs0[i]), 1);
            chk("bp_after_valid", 32'(vld_all[i]), 0);
            chk("bp_after_ready", 32'(rdy_all[i]), 1);
        end

        // Asynchronous reset one cycle into BUSY discards the vector.
        send(pk(9, 8, 7, 6, 5), 2'd2, 4'd3);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("midrst_valid", 32'(vld_all[i]), 0);
            chk("midrst_ready", 32'(rdy_all[i]), 1);
            chk("midrst_data", 32'(data_all[i]), 0);
            chk("midrst_sat", 32'(sat_all[i]), 0);
            exp_q[i].delete();
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_dir("pass_after_rst", pk(5, 4, 3, 2, 1), 2'd0, 4'd0, pk(5, 4, 3, 2, 1), 0);

        // Random vectors with random backpressure and input churn while busy.
        for (int t = 0; t < 40; t++) begin
            rd    = DW'($urandom);
            rop   = 2'($urandom);
            ropnd = WIDTH'($urandom);
            send(rd, rop, ropnd);
            drain(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
